// File: rtl/upc_seq_pkg.sv
// Shared types for the up-counter sequencing controller: FSM state encoding and default width.
// Optional feature macro: UPC_SEQ_AUTORELOAD_EN (consumed by upc_seq_ctrl).
package upc_seq_pkg;

  localparam int UPC_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } upc_state_e;

endpackage

// File: rtl/upc_core.sv
// Loadable WIDTH-bit up counter; load wins over count, one-edge latency, no backpressure.
// co flags the all-ones to zero wrap in the same cycle the increment is enabled.
module upc_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             cen,
  input  logic             ci,
  input  logic [WIDTH-1:0] parIn,
  output logic [WIDTH-1:0] parOut,
  output logic             co
);

  always_ff @(posedge clk) begin
    if (rst) begin
      parOut <= '0;
    end else if (ld) begin
      parOut <= parIn;
    end else if (cen && ci) begin
      parOut <= parOut + WIDTH'(1);
    end
  end

  assign co = cen && ci && (parOut == {WIDTH{1'b1}});

endmodule

// File: rtl/upc_seq_ctrl.sv
// Command-driven sequencer for upc_core: load start, count to stop, pulse done; N+4 cycles per command.
// Backpressure: cmd_ready only in IDLE; UPC_SEQ_AUTORELOAD_EN makes DONE reload and repeat until abort.
module upc_seq_ctrl
  import upc_seq_pkg::*;
#(
  parameter int WIDTH = UPC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_stop,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt_out,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  upc_state_e       state_q;
  upc_state_e       state_d;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] stop_q;
  logic             ld;
  logic             cen;
  logic             co;
  logic             accept;

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    cen     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = LOAD;
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          ld      = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Abort beats reaching stop; the counter is frozen in both cases.
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_out == stop_q) begin
          state_d = DONE;
        end else begin
          cen = !pause;
        end
      end
      DONE: begin
`ifdef UPC_SEQ_AUTORELOAD_EN
        state_d = LOAD;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= '0;
      stop_q  <= '0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        start_q <= cmd_start;
        stop_q  <= cmd_stop;
      end
      // Entering LOAD starts a fresh pass, so the wrap flag restarts too.
      if (state_d == LOAD && state_q != LOAD) begin
        ovf <= 1'b0;
      end else if (co) begin
        ovf <= 1'b1;
      end
    end
  end

  upc_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .ld     (ld),
    .cen    (cen),
    .ci     (cen),
    .parIn  (start_q),
    .parOut (cnt_out),
    .co     (co)
  );

endmodule
